sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 121 ++++++++++++
 tb/tb_sram_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// MEM-stage bridge to a 64-bit-wide asynchronous SRAM. Reads take one timed phase; writes are
// done as read-modify-write of a whole 64-bit line.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    inout  wire  [63:0] SRAM_DQ,
    output logic [16:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    localparam logic [31:0] Base    = 32'(BASE_ADDR);
    localparam logic [3:0]  LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [16:0] addr_q;
    logic        half_q;
    logic        wr_pend_q;
    logic [31:0] wdata_q;
    logic [63:0] line_q;
    logic [31:0] rdata_q;
    logic        we_n_q;
    logic        dq_oe_q;

    logic [31:0] offs;
    logic        last_cycle;
    logic        abort;
    logic [63:0] wr_line;
    logic        unused_offs;

    assign offs        = address - Base;
    assign unused_offs = ^{offs[31:20], offs[1:0]};
    assign last_cycle  = (cnt_q == LastCnt);
    assign abort       = !rd_en && !wr_en;

    // Only the addressed half of the line is replaced; the other half is written back as read.
    assign wr_line = half_q ? {wdata_q, line_q[31:0]} : {line_q[63:32], wdata_q};

    assign SRAM_DQ   = dq_oe_q ? wr_line : 64'bz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign rdata     = rdata_q;
    assign ready     = abort || (state_q == StDone);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= 17'd0;
            half_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            wdata_q   <= 32'd0;
            line_q    <= 64'd0;
            rdata_q   <= 32'd0;
            we_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rd_en || wr_en) begin
                        addr_q    <= offs[19:3];
                        half_q    <= offs[2];
                        wr_pend_q <= wr_en;
                        if (wr_en) begin
                            wdata_q <= wdata;
                        end
                        cnt_q   <= 4'd0;
                        state_q <= StRd;
                    end
                end
                StRd: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (last_cycle) begin
                        line_q <= SRAM_DQ;
                        cnt_q  <= 4'd0;
                        if (wr_pend_q) begin
                            state_q <= StWr;
                            we_n_q  <= 1'b0;
                            dq_oe_q <= 1'b1;
                        end else begin
                            rdata_q <= half_q ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
                            state_q <= StDone;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StWr: begin
                    if (abort || last_cycle) begin
                        state_q <= abort ? StIdle : StDone;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: a behavioural SRAM on the bus plus a line-level
// reference memory that predicts load data, latencies and read-modify-write results.
module tb_sram_controller;

    localparam int unsigned W    = 5;
    localparam int unsigned BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    wire  [63:0] SRAM_DQ;
    logic [16:0] SRAM_ADDR;
    logic        SRAM_WE_N;

    int errors = 0;
    int checks = 0;

    logic [63:0] sram    [256];
    logic [63:0] ref_mem [256];
    logic [31:0] ref_rdata;

    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [63:0] pl_val = 64'd0;

    sram_controller #(
        .WAIT_CYCLES(W),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .SRAM_DQ  (SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: drives the bus whenever it is not being written.
    assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR[7:0]] : 64'bz;

    always @(posedge clk) begin
        if (pl_en) sram[pl_idx] <= pl_val;
        else if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= SRAM_DQ;
    end

    function automatic logic [63:0] merge(input logic [63:0] old, input logic h,
                                          input logic [31:0] d);
        return h ? {d, old[31:0]} : {old[63:32], d};
    endfunction

    task automatic preload(input int idx, input logic [63:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx[7:0];
        pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Issues one request, scrambles address/wdata mid-access, and waits (bounded) for ready.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output int we_low,
                          output logic [16:0] addr_seen);
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = addr; wdata = wd;
        lat = 0; we_low = 0; addr_seen = '1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) addr_seen = SRAM_ADDR;
            if (lat == 2) begin
                address = $urandom;
                wdata   = $urandom;
            end
            if (!SRAM_WE_N) we_low++;
        end while (!ready && lat < 100);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
        ref_rdata = 32'd0;
        #2;
        checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b want 1", SRAM_WE_N); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (SRAM_ADDR !== 17'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", SRAM_ADDR); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read();
        int lat, wl; logic [16:0] as;
        preload(0, 64'hAAAA_BBBB_1111_2222);
        access(1'b1, 1'b0, 32'd1028, 32'd0, lat, wl, as);
        ref_rdata = ref_mem[0][63:32];
        checks++; if (lat != W + 1) begin errors++; $display("FAIL read_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (rdata !== 32'hAAAA_BBBB) begin errors++; $display("FAIL read_data: got %h want aaaabbbb", rdata); end
        checks++; if (as !== 17'd0) begin errors++; $display("FAIL read_addr: got %h want 0", as); end
        checks++; if (wl != 0) begin errors++; $display("FAIL read_we_n: got %0d low cycles want 0", wl); end
    endtask

    task automatic test_write();
        int lat, wl; logic [16:0] as;
        preload(1, 64'h5555_6666_7777_8888);
        access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, lat, wl, as);
        ref_mem[1] = merge(ref_mem[1], 1'b0, 32'hDEAD_BEEF);
        checks++; if (lat != 2 * W + 1) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, 2 * W + 1); end
        checks++; if (wl != W) begin errors++; $display("FAIL write_we_low: got %0d want %0d", wl, W); end
        checks++; if (sram[1] !== 64'h5555_6666_DEAD_BEEF) begin errors++; $display("FAIL write_word: got %h want 55556666deadbeef", sram[1]); end
        checks++; if (as !== 17'd1) begin errors++; $display("FAIL write_addr: got %h want 1", as); end
        checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL write_rdata_kept: got %h want %h", rdata, ref_rdata); end
    endtask

    task automatic test_both();
        int lat, wl; logic [16:0] as; logic [31:0] wd;
        wd = $urandom;
        access(1'b1, 1'b1, 32'd1024, wd, lat, wl, as);
        ref_mem[0] = merge(ref_mem[0], 1'b0, wd);
        checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL both_rdata_kept: got %h want %h", rdata, ref_rdata); end
        checks++; if (sram[0] !== ref_mem[0]) begin errors++; $display("FAIL both_word: got %h want %h", sram[0], ref_mem[0]); end
        checks++; if (wl != W) begin errors++; $display("FAIL both_we_low: got %0d want %0d", wl, W); end
    endtask

    task automatic test_abort();
        int lat, wl; logic [16:0] as; logic [31:0] wd;
        wd = $urandom;
        preload(2, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b1; address = BASE + 20; wdata = wd;
        repeat (W + 3) @(posedge clk);
        #1;
        checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL abort_in_wr: got we_n=%b want 0", SRAM_WE_N); end
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        ref_mem[2] = merge(ref_mem[2], 1'b1, wd);
        checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL abort_we_n: got %b want 1", SRAM_WE_N); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", ready); end
        checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL abort_rdata: got %h want %h", rdata, ref_rdata); end
        checks++; if (sram[2] !== ref_mem[2]) begin errors++; $display("FAIL abort_word: got %h want %h", sram[2], ref_mem[2]); end
        // A fresh read must start from idle with normal latency.
        access(1'b1, 1'b0, BASE + 20, 32'd0, lat, wl, as);
        ref_rdata = ref_mem[2][63:32];
        checks++; if (lat != W + 1) begin errors++; $display("FAIL abort_next_latency: got %0d want %0d", lat, W + 1); end
        checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL abort_next_data: got %h want %h", rdata, ref_rdata); end
    endtask

    task automatic test_async_reset();
        logic [31:0] wd;
        wd = $urandom;
        preload(3, 64'hFEDC_BA98_7654_3210);
        @(negedge clk);
        wr_en = 1'b1; address = BASE + 24; wdata = wd;
        repeat (W + 2) @(posedge clk);
        #3;
        checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL areset_pre_we_n: got %b want 0", SRAM_WE_N); end
        rst = 1'b1;
        #1;
        ref_rdata = 32'd0;
        ref_mem[3] = merge(ref_mem[3], 1'b0, wd);
        checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL areset_we_n: got %b want 1", SRAM_WE_N); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL areset_rdata: got %h want 0", rdata); end
        checks++; if (SRAM_DQ !== sram[0]) begin errors++; $display("FAIL areset_dq: got %h want %h", SRAM_DQ, sram[0]); end
        #1 rst = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL areset_after_we_n: got %b want 1", SRAM_WE_N); end
        checks++; if (sram[3] !== ref_mem[3]) begin errors++; $display("FAIL areset_word: got %h want %h", sram[3], ref_mem[3]); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        rd_en = 1'b1; address = BASE;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 100);
        checks++; if (rdata !== ref_mem[0][31:0]) begin errors++; $display("FAIL b2b_first_data: got %h want %h", rdata, ref_mem[0][31:0]); end
        @(negedge clk);
        address = BASE + 12;
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_first_width: got ready=%b want 0", ready); end
        n = 1;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 100);
        checks++; if (n != W + 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles want %0d", n, W + 2); end
        checks++; if (rdata !== ref_mem[1][63:32]) begin errors++; $display("FAIL b2b_second_data: got %h want %h", rdata, ref_mem[1][63:32]); end
        ref_rdata = ref_mem[1][63:32];
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_width: got ready=%b want 0", ready); end
        @(negedge clk);
        rd_en = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_random();
        int lat, wl, op, word; logic h; logic [16:0] as; logic [31:0] addr, wd;
        logic [31:0] lo, hi;
        for (int i = 0; i < 16; i++) begin
            lo = $urandom; hi = $urandom;
            preload(i, {hi, lo});
        end
        for (int i = 0; i < 40; i++) begin
            op   = $urandom_range(0, 2);
            word = $urandom_range(0, 15);
            h    = 1'($urandom_range(0, 1));
            addr = BASE + 32'(word * 8) + (h ? 32'd4 : 32'd0) + 32'($urandom_range(0, 3));
            wd   = $urandom;
            access(op != 1, op != 0, addr, wd, lat, wl, as);
            if (op == 0) begin
                ref_rdata = h ? ref_mem[word][63:32] : ref_mem[word][31:0];
                checks++; if (lat != W + 1) begin errors++; $display("FAIL rand_rd_latency[%0d]: got %0d want %0d", i, lat, W + 1); end
            end else begin
                ref_mem[word] = merge(ref_mem[word], h, wd);
                checks++; if (lat != 2 * W + 1) begin errors++; $display("FAIL rand_wr_latency[%0d]: got %0d want %0d", i, lat, 2 * W + 1); end
                checks++; if (wl != W) begin errors++; $display("FAIL rand_wr_we_low[%0d]: got %0d want %0d", i, wl, W); end
            end
            checks++; if (rdata !== ref_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, rdata, ref_rdata); end
            checks++; if (as !== 17'(word)) begin errors++; $display("FAIL rand_addr[%0d]: got %h want %h", i, as, word); end
            checks++; if (sram[word] !== ref_mem[word]) begin errors++; $display("FAIL rand_word[%0d]: got %h want %h", i, sram[word], ref_mem[word]); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_both();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
